// File: rtl/mpram_nr1w_clr_pkg.sv
// Shared types and helpers for the N-read / 1-write clearable register file.
// Holds the per-port read-source selector and address-width derivation.
package mpram_nr1w_clr_pkg;

    // Where a read port takes its data from in a given cycle.
    typedef enum logic [1:0] {
        SRC_MEM = 2'd0,
        SRC_CLR = 2'd1,
        SRC_BYP = 2'd2
    } rd_src_e;

    function automatic int abw_of(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mpram_nr1w_clr_bank.sv
// One 1R1W bank, WIDTH x DEPTH, asynchronous read, no reset (initialised by the owner's sweep).
// Zero read latency; write lands at the rising edge; no backpressure.
module mpram_nr1w_clr_bank #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 32,
    parameter int ABW   = 5
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ABW-1:0]   i_wa,
    input  logic [WIDTH-1:0] i_wd,
    input  logic [ABW-1:0]   i_ra,
    output logic [WIDTH-1:0] o_rd
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/mpram_nr1w_clr.sv
// N-read / 1-write register file with clear sweep and write-through bypass; reads are
// combinational (RDREG=0) or 1-cycle registered (RDREG=1); writes are dropped while BUSY.
module mpram_nr1w_clr
    import mpram_nr1w_clr_pkg::*;
#(
    parameter int               WIDTH   = 2,
    parameter int               DEPTH   = 32,
    parameter int               NRD     = 3,
    parameter int               BYPASS  = 1,
    parameter int               RDREG   = 0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0,
    localparam int              ABW     = abw_of(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    output logic                 o_busy,
    input  logic                 i_wen,
    input  logic [ABW-1:0]       i_aw,
    input  logic [WIDTH-1:0]     i_di,
    input  logic                 i_cen,
    input  logic [NRD*ABW-1:0]   i_a,
    output logic [NRD*WIDTH-1:0] o_q
);

    localparam logic [ABW-1:0] LAST_IDX = ABW'(DEPTH - 1);
    localparam logic [ABW:0]   DEPTH_X  = (ABW + 1)'(DEPTH);

    logic [ABW-1:0]   r_cnt;
    logic             r_busy;
    logic             w_aw_ok;
    logic             w_we;
    logic [ABW-1:0]   w_wa;
    logic [WIDTH-1:0] w_wd;
    logic             w_unused_cen;

    // A CLR during a sweep simply restarts it from entry 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == LAST_IDX) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + ABW'(1);
            end
        end
    end

    assign o_busy  = r_busy;
    assign w_aw_ok = ({1'b0, i_aw} < DEPTH_X);

    // Sweep owns the write port while busy; out-of-range user writes never reach the banks.
    assign w_we = r_busy | (i_wen & w_aw_ok);
    assign w_wa = r_busy ? r_cnt : i_aw;
    assign w_wd = r_busy ? CLR_VAL : i_di;

    assign w_unused_cen = i_cen;

    for (genvar g = 0; g < NRD; g++) begin : g_port
        logic [ABW-1:0]   w_ra;
        logic [WIDTH-1:0] w_mem_q;
        logic [WIDTH-1:0] w_data;
        rd_src_e          w_src;

        assign w_ra = i_a[g*ABW +: ABW];

        mpram_nr1w_clr_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ABW   (ABW)
        ) u_bank (
            .i_clk (i_clk),
            .i_we  (w_we),
            .i_wa  (w_wa),
            .i_wd  (w_wd),
            .i_ra  (w_ra),
            .o_rd  (w_mem_q)
        );

        // Mask wins over bypass: a busy array never exposes stale or in-flight data.
        always_comb begin
            w_src = SRC_MEM;
            if (r_busy || ({1'b0, w_ra} >= DEPTH_X)) begin
                w_src = SRC_CLR;
            end else if ((BYPASS != 0) && i_wen && (w_ra == i_aw)) begin
                w_src = SRC_BYP;
            end
        end

        always_comb begin
            case (w_src)
                SRC_CLR: w_data = CLR_VAL;
                SRC_BYP: w_data = i_di;
                default: w_data = w_mem_q;
            endcase
        end

        if (RDREG != 0) begin : g_reg
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_q <= CLR_VAL;
                end else if (i_cen) begin
                    r_q <= w_data;
                end
            end

            assign o_q[g*WIDTH +: WIDTH] = r_q;
        end else begin : g_comb
            assign o_q[g*WIDTH +: WIDTH] = w_data;
        end
    end

endmodule
